// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: IF-stage program counter sequencer with a single-outstanding
// req/gnt/rvalid fetch port and a one-entry fetched-instruction buffer.
// Branch redirects flush the buffer and squash any fetch already in flight.
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned branch target flag;
// when defined, targets are forced to word alignment).
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] b_tgt_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_instr_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        squash_q, squash_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic        misalign_q, misalign_d;
  logic        req;
  logic [31:0] tgt;

`ifdef PC_ALIGN_CHECK_EN
  // Redirects always land on a word boundary; a non-zero low pair is flagged.
  assign tgt = {b_tgt_i[31:2], 2'b00};
  assign misalign_d = branch_i && (b_tgt_i[1:0] != 2'b00);
`else
  assign tgt = b_tgt_i;
  assign misalign_d = 1'b0;
`endif

  // Request only from S_REQ, and never while a stalled buffer is still full.
  assign req = (state_q == S_REQ) && !(if_valid_q && stall_i);

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign if_valid_o  = if_valid_q;
  assign if_pc_o     = if_pc_q;
  assign if_instr_o  = if_instr_q;
  assign misalign_o  = misalign_q;

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= 32'd0;
      squash_q   <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_instr_q <= 32'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      squash_q   <= squash_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state: fetch sequencing, buffer fill/drain, branch redirect on top.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    squash_d   = squash_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;

    // Buffer drains whenever downstream is not stalled.
    if (if_valid_q && !stall_i) begin
      if_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (req && imem_gnt_i) begin
          req_pc_d = pc_q;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = S_REQ;
          if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_instr_d = imem_rdata_i;
            pc_d       = req_pc_q + PC_INC;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Redirect wins over stall and over any response arriving this cycle.
    if (branch_i) begin
      pc_d       = tgt;
      if_valid_d = 1'b0;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;
      if (state_q == S_REQ && req && imem_gnt_i) begin
        squash_d = 1'b1;
      end else if (state_q == S_WAIT) begin
        squash_d = !imem_rvalid_i;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed testbench for pc_fetch_ctrl: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] b_tgt_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        misalign_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall_i),
    .branch_i     (branch_i),
    .b_tgt_i      (b_tgt_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .if_valid_o   (if_valid_o),
    .if_pc_o      (if_pc_o),
    .if_instr_o   (if_instr_o),
    .misalign_o   (misalign_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant in the request cycle, respond the cycle after.
  task automatic do_fetch(input logic [31:0] d);
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i = d;
    step();
    imem_rvalid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0; b_tgt_i = 32'd0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    step(); step();
    vectors++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); end
    vectors++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", imem_req_o); end
    vectors++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if_valid_o); end
    vectors++; if (if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin errors++; $display("FAIL reset_buf: got %h/%h want 0/0", if_pc_o, if_instr_o); end
    vectors++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b want 0", misalign_o); end
    $display("reset: pc=%h req=%b valid=%b", pc_o, imem_req_o, if_valid_o);
    rst = 1'b0;
    step();
  endtask

  task automatic test_sequential();
    vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL seq_req0: got req=%b addr=%h want 1/0", imem_req_o, imem_addr_o); end
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    vectors++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL seq_wait_req: got %b want 0", imem_req_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h11;
    step();
    imem_rvalid_i = 1'b0;
    vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h11) begin errors++; $display("FAIL seq_buf0: got %b %h %h want 1 0 11", if_valid_o, if_pc_o, if_instr_o); end
    vectors++; if (imem_addr_o !== 32'h4 || imem_req_o !== 1'b1) begin errors++; $display("FAIL seq_addr1: got %h req=%b want 4/1", imem_addr_o, imem_req_o); end
    $display("seq fetch0: if_pc=%h instr=%h next=%h", if_pc_o, if_instr_o, imem_addr_o);
    do_fetch(32'h22);
    vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h4 || if_instr_o !== 32'h22) begin errors++; $display("FAIL seq_buf1: got %b %h %h want 1 4 22", if_valid_o, if_pc_o, if_instr_o); end
    $display("seq fetch1: if_pc=%h instr=%h next=%h", if_pc_o, if_instr_o, imem_addr_o);
  endtask

  task automatic test_stall();
    do_fetch(32'h33);
    stall_i = 1'b1;
    #1;
    vectors++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req0: got %b want 0", imem_req_o); end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8 || if_instr_o !== 32'h33 || imem_req_o !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h req=%b want 1 8 33 0", i, if_valid_o, if_pc_o, if_instr_o, imem_req_o);
      end
    end
    stall_i = 1'b0;
    #1;
    vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin errors++; $display("FAIL stall_resume: got req=%b addr=%h want 1/C", imem_req_o, imem_addr_o); end
    $display("stall: held pc=8, resume addr=%h", imem_addr_o);
    do_fetch(32'h44);
    vectors++; if (if_pc_o !== 32'hC || imem_addr_o !== 32'h10) begin errors++; $display("FAIL stall_after: got %h/%h want C/10", if_pc_o, imem_addr_o); end
  endtask

  task automatic test_branch_wait();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    branch_i = 1'b1; b_tgt_i = 32'h100;
    step();
    branch_i = 1'b0;
    vectors++; if (if_valid_o !== 1'b0 || pc_o !== 32'h100 || imem_req_o !== 1'b0) begin errors++; $display("FAIL bwait_redirect: got v=%b pc=%h req=%b want 0 100 0", if_valid_o, pc_o, imem_req_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD;
    step();
    imem_rvalid_i = 1'b0;
    vectors++; if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin errors++; $display("FAIL bwait_discard: got v=%b addr=%h req=%b want 0 100 1", if_valid_o, imem_addr_o, imem_req_o); end
    do_fetch(32'h55);
    vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h100 || if_instr_o !== 32'h55) begin errors++; $display("FAIL bwait_refetch: got %b %h %h want 1 100 55", if_valid_o, if_pc_o, if_instr_o); end
    $display("branch in wait: if_pc=%h instr=%h", if_pc_o, if_instr_o);
  endtask

  task automatic test_branch_coincident();
    // Branch in the same cycle as the grant.
    imem_gnt_i = 1'b1; branch_i = 1'b1; b_tgt_i = 32'h200;
    step();
    imem_gnt_i = 1'b0; branch_i = 1'b0;
    vectors++; if (if_valid_o !== 1'b0 || pc_o !== 32'h200) begin errors++; $display("FAIL bgnt_redirect: got v=%b pc=%h want 0 200", if_valid_o, pc_o); end
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD;
    step();
    imem_rvalid_i = 1'b0;
    vectors++; if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h200 || imem_req_o !== 1'b1) begin errors++; $display("FAIL bgnt_discard: got v=%b addr=%h req=%b want 0 200 1", if_valid_o, imem_addr_o, imem_req_o); end
    // Branch in the same cycle as the response.
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD2; branch_i = 1'b1; b_tgt_i = 32'h300;
    step();
    imem_rvalid_i = 1'b0; branch_i = 1'b0;
    vectors++; if (if_valid_o !== 1'b0 || imem_addr_o !== 32'h300 || imem_req_o !== 1'b1) begin errors++; $display("FAIL brv_drop: got v=%b addr=%h req=%b want 0 300 1", if_valid_o, imem_addr_o, imem_req_o); end
    do_fetch(32'h66);
    vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h300 || if_instr_o !== 32'h66) begin errors++; $display("FAIL brv_refetch: got %b %h %h want 1 300 66", if_valid_o, if_pc_o, if_instr_o); end
    $display("branch coincident: if_pc=%h instr=%h", if_pc_o, if_instr_o);
  endtask

  task automatic test_reset_mid();
    imem_gnt_i = 1'b1;
    step();
    imem_gnt_i = 1'b0;
    rst = 1'b1;
    step();
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h77;
    step();
    vectors++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0 || pc_o !== 32'h0 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_outs: got v=%b pc=%h i=%h pc_o=%h req=%b want all 0", if_valid_o, if_pc_o, if_instr_o, pc_o, imem_req_o);
    end
    rst = 1'b0; imem_rvalid_i = 1'b0;
    step();
    vectors++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_first: got req=%b addr=%h v=%b want 1 0 0", imem_req_o, imem_addr_o, if_valid_o); end
    do_fetch(32'h88);
    vectors++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h88) begin errors++; $display("FAIL rstmid_fetch: got %b %h %h want 1 0 88", if_valid_o, if_pc_o, if_instr_o); end
    $display("reset mid-transaction: first fetch if_pc=%h instr=%h", if_pc_o, if_instr_o);
  endtask

  task automatic test_misalign();
    logic [31:0] exp_pc;
    logic        exp_mis;
`ifdef PC_ALIGN_CHECK_EN
    exp_pc = 32'h100; exp_mis = 1'b1;
`else
    exp_pc = 32'h103; exp_mis = 1'b0;
`endif
    branch_i = 1'b1; b_tgt_i = 32'h103;
    step();
    branch_i = 1'b0;
    vectors++; if (pc_o !== exp_pc || misalign_o !== exp_mis) begin errors++; $display("FAIL misalign_branch: got pc=%h mis=%b want %h %b", pc_o, misalign_o, exp_pc, exp_mis); end
    step();
    vectors++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b want 0", misalign_o); end
    $display("misalign: pc=%h", pc_o);
  endtask

  task automatic test_wrap();
    branch_i = 1'b1; b_tgt_i = 32'hFFFF_FFFC;
    step();
    branch_i = 1'b0;
    do_fetch(32'h99);
    vectors++; if (if_pc_o !== 32'hFFFF_FFFC || if_instr_o !== 32'h99 || pc_o !== 32'h0) begin errors++; $display("FAIL wrap: got if_pc=%h i=%h pc=%h want FFFFFFFC 99 0", if_pc_o, if_instr_o, pc_o); end
    $display("wrap: if_pc=%h next=%h", if_pc_o, pc_o);
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_coincident();
    test_reset_mid();
    test_misalign();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Sequences the 32-bit program counter and issues one instruction-memory fetch at a time over a req/gnt/rvalid handshake.
- Accepts branch redirects (PCSrc plus target) and squashes any fetch already in flight.
- Holds a one-entry fetched-instruction buffer that honours a pipeline stall from hazard logic.
- Sits between the IF-stage PC register path and instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 32'd4, sequential PC increment.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset: rst, synchronous, active-high.
- stall_i  input  1  downstream stall; holds the fetch buffer contents.
- branch_i  input  1  PCSrc, redirect request, one-cycle pulse.
- b_tgt_i  input  32  branch target, sampled when branch_i=1.
- imem_req_o  output  1  fetch request.
- imem_addr_o  output  32  fetch address; always equals pc_o.
- imem_gnt_i  input  1  memory accepted the request this cycle.
- imem_rvalid_i  input  1  read data valid.
- imem_rdata_i  input  32  fetched instruction.
- pc_o  output  32  next fetch address.
- if_valid_o  output  1  fetch buffer holds a valid instruction.
- if_pc_o  output  32  PC of the buffered instruction.
- if_instr_o  output  32  buffered instruction.
- misalign_o  output  1  misaligned branch target flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at edge):
  - state=S_IDLE, pc_o=RESET_PC.
  - imem_req_o=0, if_valid_o=0, if_pc_o=0, if_instr_o=0, misalign_o=0.
  - squash flag=0.
  - Reset overrides every other input, including mid-transaction; late rvalid after reset is ignored.
- S_IDLE: transitions to S_REQ on the next edge unconditionally. imem_req_o=0.
- S_REQ:
  - imem_req_o = !(if_valid_o && stall_i). This is combinational from state; it does not depend on gnt.
  - When req=1 and gnt=1: latch req_pc=pc_o and move to S_WAIT.
  - Only one fetch is outstanding at any time.
- S_WAIT:
  - imem_req_o=0.
  - On rvalid with squash=0: if_valid_o<=1, if_pc_o<=req_pc, if_instr_o<=rdata, pc_o<=req_pc+PC_INC (mod 2^32, wraps silently), go to S_REQ.
  - On rvalid with squash=1: discard the data, clear squash, go to S_REQ.
- Fetch buffer:
  - Drains when if_valid_o=1 and stall_i=0: if_valid_o<=0 unless refilled by rvalid in the same cycle.
  - Invariant: the buffer is empty or draining whenever rvalid arrives.
- Branch (branch_i=1), highest priority after rst, overrides stall_i:
  - pc_o<=b_tgt_i.
  - if_valid_o<=0 in the same edge (flush).
  - In S_REQ without gnt: stay in S_REQ; next cycle's address = target.
  - In S_REQ with gnt in the same cycle: go to S_WAIT, squash<=1.
  - In S_WAIT without rvalid: squash<=1.
  - In S_WAIT with rvalid in the same cycle: drop the data, go to S_REQ, squash<=0.
  - Repeated branches while squashed: the last target wins and squash stays set.
- Latency: gnt and rvalid in consecutive cycles give if_valid_o two cycles after the request edge. Back-to-back fetches sustain 1 instruction per 2 cycles.

Optional Feature:
- Macro name: PC_ALIGN_CHECK_EN.
- Defined:
  - When branch_i=1 and b_tgt_i[1:0]!=0, misalign_o pulses high for one cycle.
  - The redirect still occurs, with pc_o<={b_tgt_i[31:2],2'b00}.
- Undefined:
  - misalign_o is tied to 0.
  - The target is used unmodified.

Test Plan:
- Reset then sequential fetch: rst for 2 cycles; gnt immediate, rvalid next cycle, rdata=0x11,0x22 -> imem_addr_o 0x0 then 0x4; if_pc_o/if_instr_o = 0x0/0x11, then 0x4/0x22.
- Stall hold: buffer valid at pc 0x8, stall_i=1 for 3 cycles -> if_valid_o, if_pc_o=0x8 and if_instr_o stable; imem_req_o=0 throughout; request resumes (addr 0xC) on the first cycle stall_i=0.
- Branch in S_WAIT: request to 0x10 granted, branch_i=1 with b_tgt_i=0x100 before rvalid -> response discarded, if_valid_o=0, next imem_addr_o=0x100, and the buffer later shows if_pc_o=0x100.
- Branch coincident with gnt and with rvalid: both cases -> no instruction from the old path ever appears with if_valid_o=1; next fetch address=target.
- Reset mid-transaction: rst asserted in S_WAIT, then rvalid arrives during reset -> all outputs at reset values; the first fetch after reset is at RESET_PC.
- With PC_ALIGN_CHECK_EN: b_tgt_i=0x103 -> misalign_o=1 for one cycle and pc_o=0x100. Without the macro: misalign_o stays 0 and pc_o=0x103.
